fb_scanout: RTL and testbench
=============================

Name: fb_scanout

Overview:
- Display-side reader of the 1-bit video buffer that the Bresenham line engine writes into.
- Takes timing from Vga_Sync and issues buffer read addresses {pixel_x[9:0], pixel_y[8:0]}.
- Absorbs the buffer read latency by delaying sync/video_on to match, and emits registered RGB plus syncs.
- Owns the buffer write port. It passes line-engine pixel writes through with a ready handshake, and runs a frame-clear FSM that zeroes the whole buffer on request.

Parameters:
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- RD_LAT, 1, video_buffer read latency in clk cycles (1..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_x  in  10  scan column from Vga_Sync
- pixel_y  in  10  scan row from Vga_Sync; bits [8:0] used
- h_sync_in  in  1  from Vga_Sync
- v_sync_in  in  1  from Vga_Sync
- video_on_in  in  1  from Vga_Sync
- buf_rd_addr  out  19  {pixel_x[9:0], pixel_y[8:0]}; combinational
- buf_rd_data  in  1  buffer read data, valid RD_LAT cycles after address
- buf_wr_addr  out  19  write address {x[9:0], y[8:0]}
- buf_we  out  1  write strobe
- buf_wr_data  out  1  write data
- draw_valid  in  1  line engine presents a pixel
- draw_x  in  10  pixel column
- draw_y  in  9  pixel row
- draw_ready  out  1  write port available to the line engine
- clear_req  in  1  start full-buffer clear (level-sampled)
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse after the last clear write
- h_sync  out  1  delayed sync
- v_sync  out  1  delayed sync
- rgb  out  3  pixel colour

Behaviour:
- Reset values: h_sync=0, v_sync=0, rgb=000, buf_we=0, buf_wr_data=0, buf_wr_addr=0, clear_busy=0, clear_done=0, draw_ready=1. The delay pipeline is cleared to zeros.
- Scan path:
  - h_sync_in, v_sync_in and video_on_in pass through an RD_LAT-stage shift register.
  - Output register: rgb <= video_on_d ? {3{buf_rd_data}} : 000.
  - h_sync and v_sync are registered alongside rgb, so total latency from pixel_x/y change to rgb/sync is RD_LAT+1 cycles, and the syncs stay aligned with rgb.
- FSM states:
  - IDLE: draw_ready=1. If clear_req=1 go to CLEAR with cx=0, cy=0. clear_req takes priority over a simultaneous draw_valid; that draw is not accepted, because draw_ready drops the same cycle (combinational from state/clear_req).
  - CLEAR: buf_we=1, buf_wr_data=0, addr={cx,cy}. cy increments to V_ACTIVE-1 then wraps to 0 and increments cx. After {H_ACTIVE-1, V_ACTIVE-1} go to DONE. Takes exactly H_ACTIVE*V_ACTIVE cycles. draw_ready=0, clear_busy=1, clear_req ignored.
  - DONE: one cycle; clear_done=1, clear_busy=0, then IDLE.
- Draw pass-through (IDLE only):
  - A transfer occurs when draw_valid && draw_ready.
  - Next cycle: buf_we=1, buf_wr_data=1, buf_wr_addr={draw_x, draw_y}. Registered, 1-cycle latency, one pixel per cycle sustained.
  - Out-of-range pixels (draw_x>=H_ACTIVE or draw_y>=V_ACTIVE) are accepted but produce no write.
- Reads continue unaffected during clear; rgb shows the partially cleared frame.
- Reset mid-clear aborts immediately to IDLE with no clear_done pulse. Buffer contents are undefined/partial.

Optional Feature:
- SCANOUT_COLOR_EN.
- When defined: adds fg_rgb[2:0] and bg_rgb[2:0] inputs. Both are captured into shadow registers on the cycle pixel_x==0 && pixel_y==0, and rgb = video_on_d ? (pixel ? fg_sh : bg_sh) : 000. Shadow reset values: fg=111, bg=000.
- When undefined: monochrome {3{pixel}} and no extra ports.

Decomposition:
- Shared package holds: H_ACTIVE/V_ACTIVE defaults, FSM state encoding (IDLE/CLEAR/DONE), the 19-bit address width, and a pack function for {x[9:0], y[8:0]}.
- One sub-module, sync_delay: a parameterised RD_LAT-deep shift register for {h_sync, v_sync, video_on}.

Test Plan:
- Reset asserted mid-frame -> all outputs at reset values, draw_ready=1. After release with buffer preloaded 1 at (5,7): rgb=111 exactly RD_LAT+1 cycles after pixel_x=5, pixel_y=7 with video_on=1; 000 at (6,7).
- video_on_in=0 with buf_rd_data=1 -> rgb=000. h_sync/v_sync edges appear RD_LAT+1 cycles after the inputs, for RD_LAT=1 and RD_LAT=3.
- Streaming draw of pixels (0,0),(1,1),(2,2) on consecutive cycles -> buf_we=1 on the three following cycles with addresses 0x00000, 0x00201, 0x00402 and data 1. Pixel (700,3) -> accepted, no buf_we.
- clear_req pulse with H_ACTIVE=4, V_ACTIVE=3 -> 12 consecutive zero writes in order (0,0),(0,1),(0,2),(1,0)…(3,2); clear_done high one cycle later; draw_ready=0 throughout.
- clear_req and draw_valid in the same cycle -> draw not accepted, clear starts. Draw accepted on the first IDLE cycle after clear_done.
- Reset asserted at clear write 5 -> clear_busy=0 immediately, no clear_done, buf_we=0.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
// Shared definitions for the frame-buffer scanout block: default raster size,
// clear-FSM state encoding, buffer address width and the {x, y} address packer.
package fb_scanout_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  // Buffer address is {x[9:0], y[8:0]}.
  localparam int unsigned ADDR_W = 19;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } clr_state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [9:0] x, input logic [8:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/fb_scanout_sync_delay.sv
// Fixed-depth shift register that delays the raster timing bits so they line
// up with data returning from the video buffer.
module sync_delay #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] stage_q [Depth];

  // Shift one stage per clock; reset clears every stage to zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[Depth-1];

endmodule

// File: rtl/fb_scanout.sv
// Display-side reader of the 1-bit video buffer plus owner of its write port.
// The scan path issues read addresses from the raster position, delays the
// syncs by the buffer read latency and registers RGB. The write port passes
// line-engine pixels through and runs a full-buffer clear on request.
// Optional build macro SCANOUT_COLOR_EN adds per-frame fg/bg colour inputs.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef SCANOUT_COLOR_EN
  input  logic [2:0]        fg_rgb,
  input  logic [2:0]        bg_rgb,
`endif
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              video_on_in,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic              buf_rd_data,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic              buf_we,
  output logic              buf_wr_data,
  input  logic              draw_valid,
  input  logic [9:0]        draw_x,
  input  logic [8:0]        draw_y,
  output logic              draw_ready,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              h_sync,
  output logic              v_sync,
  output logic [2:0]        rgb
);

  localparam logic [9:0] XMax = 10'(H_ACTIVE - 1);
  localparam logic [8:0] YMax = 9'(V_ACTIVE - 1);

  // ---------------------------------------------------------------------------
  // Scan path
  // ---------------------------------------------------------------------------

  assign buf_rd_addr = pack_addr(pixel_x, pixel_y[8:0]);

  // Only 480 rows are addressable; the top row bit never reaches the buffer.
  logic unused_pixel_y_msb;
  assign unused_pixel_y_msb = pixel_y[9];

  logic [2:0] timing_in;
  logic [2:0] timing_dly;
  logic       h_sync_dly;
  logic       v_sync_dly;
  logic       video_on_dly;

  assign timing_in = {h_sync_in, v_sync_in, video_on_in};

  sync_delay #(
    .Depth (RD_LAT),
    .Width (3)
  ) u_sync_delay (
    .clk_i   (clk),
    .reset_i (reset),
    .data_i  (timing_in),
    .data_o  (timing_dly)
  );

  assign h_sync_dly   = timing_dly[2];
  assign v_sync_dly   = timing_dly[1];
  assign video_on_dly = timing_dly[0];

  logic [2:0] pix_rgb;

`ifdef SCANOUT_COLOR_EN
  logic [2:0] fg_sh_q;
  logic [2:0] bg_sh_q;

  // Latch the palette at the top-left pixel so colours only change between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fg_sh_q <= 3'b111;
      bg_sh_q <= 3'b000;
    end else if (pixel_x == 10'd0 && pixel_y == 10'd0) begin
      fg_sh_q <= fg_rgb;
      bg_sh_q <= bg_rgb;
    end
  end

  assign pix_rgb = buf_rd_data ? fg_sh_q : bg_sh_q;
`else
  assign pix_rgb = {3{buf_rd_data}};
`endif

  logic       h_sync_q;
  logic       v_sync_q;
  logic [2:0] rgb_q;

  // Output register: syncs ride alongside rgb so they stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_sync_q <= 1'b0;
      v_sync_q <= 1'b0;
      rgb_q    <= 3'b000;
    end else begin
      h_sync_q <= h_sync_dly;
      v_sync_q <= v_sync_dly;
      rgb_q    <= video_on_dly ? pix_rgb : 3'b000;
    end
  end

  assign h_sync = h_sync_q;
  assign v_sync = v_sync_q;
  assign rgb    = rgb_q;

  // ---------------------------------------------------------------------------
  // Write port: draw pass-through and frame clear
  // ---------------------------------------------------------------------------

  clr_state_e        state_q, state_d;
  logic [9:0]        cx_q, cx_d;
  logic [8:0]        cy_q, cy_d;
  logic              we_q, we_d;
  logic              wd_q, wd_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic              draw_in_range;

  // Off-screen pixels are still consumed so the line engine never stalls on them.
  assign draw_in_range = (draw_x <= XMax) && (draw_y <= YMax);

  // Next-state and write-port decode. The write registers carry the write that
  // belongs to the state being entered, so (cx_q, cy_q) always match buf_wr_addr
  // while clearing.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    we_d       = 1'b0;
    wd_d       = 1'b0;
    wa_d       = wa_q;
    draw_ready = 1'b0;
    clear_busy = 1'b0;
    clear_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A clear request wins over a coincident draw, which is simply not taken.
        draw_ready = ~clear_req;
        if (clear_req) begin
          state_d = StClear;
          cx_d    = 10'd0;
          cy_d    = 9'd0;
          we_d    = 1'b1;
          wd_d    = 1'b0;
          wa_d    = pack_addr(10'd0, 9'd0);
        end else if (draw_valid && draw_in_range) begin
          we_d = 1'b1;
          wd_d = 1'b1;
          wa_d = pack_addr(draw_x, draw_y);
        end
      end

      StClear: begin
        clear_busy = 1'b1;
        if (cx_q == XMax && cy_q == YMax) begin
          state_d = StDone;
        end else begin
          // Column-major walk: y runs fastest.
          if (cy_q == YMax) begin
            cy_d = 9'd0;
            cx_d = cx_q + 10'd1;
          end else begin
            cy_d = cy_q + 9'd1;
          end
          we_d = 1'b1;
          wd_d = 1'b0;
          wa_d = pack_addr(cx_d, cy_d);
        end
      end

      StDone: begin
        clear_done = 1'b1;
        state_d    = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, clear counters and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cx_q    <= 10'd0;
      cy_q    <= 9'd0;
      we_q    <= 1'b0;
      wd_q    <= 1'b0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      wa_q    <= wa_d;
    end
  end

  assign buf_we      = we_q;
  assign buf_wr_data = wd_q;
  assign buf_wr_addr = wa_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout. Two instances share stimulus: one with a
// 1-cycle buffer read latency, one with 3. The bench owns a behavioural video
// buffer and a reference model of the scan and write paths.
module tb_fb_scanout;

  localparam int unsigned H = 4;
  localparam int unsigned V = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       h_sync_in;
  logic       v_sync_in;
  logic       video_on_in;
  logic       draw_valid;
  logic [9:0] draw_x;
  logic [8:0] draw_y;
  logic       clear_req;

  logic [18:0] rd_addr [2];
  logic        rd_data [2];
  logic [18:0] wa_o    [2];
  logic        we_o    [2];
  logic        wd_o    [2];
  logic        ready_o [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        h_o     [2];
  logic        v_o     [2];
  logic [2:0]  rgb_o   [2];

  always #5 clk = ~clk;

  fb_scanout #(.H_ACTIVE(H), .V_ACTIVE(V), .RD_LAT(1)) u_dut_lat1 (
    .clk         (clk),
    .reset       (reset),
`ifdef SCANOUT_COLOR_EN
    .fg_rgb      (3'b111),
    .bg_rgb      (3'b000),
`endif
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .video_on_in (video_on_in),
    .buf_rd_addr (rd_addr[0]),
    .buf_rd_data (rd_data[0]),
    .buf_wr_addr (wa_o[0]),
    .buf_we      (we_o[0]),
    .buf_wr_data (wd_o[0]),
    .draw_valid  (draw_valid),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .draw_ready  (ready_o[0]),
    .clear_req   (clear_req),
    .clear_busy  (busy_o[0]),
    .clear_done  (done_o[0]),
    .h_sync      (h_o[0]),
    .v_sync      (v_o[0]),
    .rgb         (rgb_o[0])
  );

  fb_scanout #(.H_ACTIVE(H), .V_ACTIVE(V), .RD_LAT(3)) u_dut_lat3 (
    .clk         (clk),
    .reset       (reset),
`ifdef SCANOUT_COLOR_EN
    .fg_rgb      (3'b111),
    .bg_rgb      (3'b000),
`endif
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .video_on_in (video_on_in),
    .buf_rd_addr (rd_addr[1]),
    .buf_rd_data (rd_data[1]),
    .buf_wr_addr (wa_o[1]),
    .buf_we      (we_o[1]),
    .buf_wr_data (wd_o[1]),
    .draw_valid  (draw_valid),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .draw_ready  (ready_o[1]),
    .clear_req   (clear_req),
    .clear_busy  (busy_o[1]),
    .clear_done  (done_o[1]),
    .h_sync      (h_o[1]),
    .v_sync      (v_o[1]),
    .rgb         (rgb_o[1])
  );

  // ---------------------------------------------------------------------------
  // Behavioural buffer and reference model (advances on each rising edge)
  // ---------------------------------------------------------------------------
  bit          mem [0:524287];
  logic        rd1 = 1'b0;
  logic [2:0]  rd3 = 3'b000;
  logic        we_s = 1'b0;
  logic        wd_s = 1'b0;
  logic [18:0] wa_s = '0;

  // Expected {h_sync, v_sync, rgb} after RD_LAT+1 edges.
  logic [4:0]  exp_a [2];
  logic [4:0]  exp_b [4];
  logic        e_we, e_wd;
  logic [18:0] e_wa;
  bit          m_clr, m_done;
  int          m_idx;
  logic        ra, rb, re;
  logic [18:0] ea;

  assign rd_data[0] = rd1;
  assign rd_data[1] = rd3[2];

  initial begin
    for (int k = 0; k < 2; k++) exp_a[k] = '0;
    for (int k = 0; k < 4; k++) exp_b[k] = '0;
    e_we = 1'b0; e_wd = 1'b0; e_wa = '0;
    m_clr = 1'b0; m_done = 1'b0; m_idx = 0;
  end

  always @(posedge clk) begin
    // Buffer reads see contents from before this edge's write.
    ra = mem[rd_addr[0]];
    rb = mem[rd_addr[1]];
    rd1 <= ra;
    rd3 <= {rd3[1:0], rb};
    ea = {pixel_x, pixel_y[8:0]};
    re = mem[ea];

    if (reset) begin
      for (int k = 0; k < 2; k++) exp_a[k] = '0;
      for (int k = 0; k < 4; k++) exp_b[k] = '0;
    end else begin
      exp_a[1] = exp_a[0];
      exp_a[0] = {h_sync_in, v_sync_in, video_on_in ? {3{re}} : 3'b000};
      for (int k = 3; k > 0; k--) exp_b[k] = exp_b[k-1];
      exp_b[0] = {h_sync_in, v_sync_in, video_on_in ? {3{re}} : 3'b000};
    end

    if (!reset && we_s) mem[wa_s] = wd_s;

    // Write-port model: a clear is H*V writes in column-major order, then one done cycle.
    if (reset) begin
      m_clr = 1'b0; m_done = 1'b0; e_we = 1'b0; e_wd = 1'b0; e_wa = '0;
    end else if (m_clr) begin
      if (m_idx == int'(H * V) - 1) begin
        m_clr = 1'b0; m_done = 1'b1; e_we = 1'b0;
      end else begin
        m_idx++;
        e_we = 1'b1; e_wd = 1'b0;
        e_wa = {10'(m_idx / int'(V)), 9'(m_idx % int'(V))};
      end
    end else if (m_done) begin
      m_done = 1'b0; e_we = 1'b0;
    end else if (clear_req) begin
      m_clr = 1'b1; m_idx = 0; e_we = 1'b1; e_wd = 1'b0; e_wa = '0;
    end else if (draw_valid && 32'(draw_x) < H && 32'(draw_y) < V) begin
      e_we = 1'b1; e_wd = 1'b1; e_wa = {draw_x, draw_y};
    end else begin
      e_we = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [4:0] et;
    for (int i = 0; i < 2; i++) begin
      et = (i == 0) ? exp_a[1] : exp_b[3];
      chk($sformatf("scan[%0d]", i), 32'({h_o[i], v_o[i], rgb_o[i]}), 32'(et));
      chk($sformatf("rd_addr[%0d]", i), 32'(rd_addr[i]), 32'({pixel_x, pixel_y[8:0]}));
      chk($sformatf("we[%0d]", i), 32'(we_o[i]), 32'(e_we));
      if (e_we) begin
        chk($sformatf("wd[%0d]", i), 32'(wd_o[i]), 32'(e_wd));
        chk($sformatf("wa[%0d]", i), 32'(wa_o[i]), 32'(e_wa));
      end
      chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_clr));
      chk($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(m_done));
      chk($sformatf("ready[%0d]", i), 32'(ready_o[i]), 32'(!m_clr && !m_done && !clear_req));
    end
    we_s = we_o[0];
    wd_s = wd_o[0];
    wa_s = wa_o[0];
  endtask

  // One clock: wait past the rising edge, then compare everything to the model.
  task automatic tick();
    @(posedge clk);
    #2;
    compare_all();
  endtask

  task automatic drive_idle();
    pixel_x = '0; pixel_y = '0; h_sync_in = 0; v_sync_in = 0; video_on_in = 0;
    draw_valid = 0; draw_x = '0; draw_y = '0; clear_req = 0;
  endtask

  task automatic lit_both(input string name, input int sel, input logic [31:0] exp);
    for (int i = 0; i < 2; i++) begin
      case (sel)
        0: chk($sformatf("%s_we[%0d]", name, i), 32'(we_o[i]), exp);
        1: chk($sformatf("%s_wd[%0d]", name, i), 32'(wd_o[i]), exp);
        2: chk($sformatf("%s_wa[%0d]", name, i), 32'(wa_o[i]), exp);
        3: chk($sformatf("%s_busy[%0d]", name, i), 32'(busy_o[i]), exp);
        4: chk($sformatf("%s_done[%0d]", name, i), 32'(done_o[i]), exp);
        5: chk($sformatf("%s_ready[%0d]", name, i), 32'(ready_o[i]), exp);
        default: chk($sformatf("%s_scan[%0d]", name, i), 32'({h_o[i], v_o[i], rgb_o[i]}), exp);
      endcase
    end
  endtask

  logic [4:0]  lit_a [6] = '{5'h00, 5'h17, 5'h08, 5'h00, 5'h00, 5'h00};
  logic [4:0]  lit_b [6] = '{5'h00, 5'h00, 5'h00, 5'h17, 5'h08, 5'h00};
  logic [18:0] clr_addr [12] = '{19'h00000, 19'h00001, 19'h00002, 19'h00200,
                                 19'h00201, 19'h00202, 19'h00400, 19'h00401,
                                 19'h00402, 19'h00600, 19'h00601, 19'h00602};
  logic [18:0] pa;

  initial begin
    reset = 1'b1;
    drive_idle();
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        pa = {10'(x), 9'(y)};
        mem[pa] = bit'($urandom_range(0, 1));
      end
    end
    pa = {10'd5, 9'd7};  mem[pa] = 1'b1;
    pa = {10'd6, 9'd7};  mem[pa] = 1'b0;

    repeat (3) tick();

    // Run mid-frame, then reset: every output returns to its reset value at once.
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      pixel_x = 10'($urandom_range(0, 15)); pixel_y = 10'($urandom_range(0, 15));
      h_sync_in = 1'($urandom); v_sync_in = 1'($urandom); video_on_in = 1'b1;
      draw_valid = 1'($urandom); draw_x = 10'($urandom_range(0, 5));
      draw_y = 9'($urandom_range(0, 3));
      tick();
      @(negedge clk);
    end
    reset = 1'b1;
    clear_req = 1'b0;
    #1;
    lit_both("rst", 6, 32'h0);
    lit_both("rst", 0, 32'h0);
    lit_both("rst", 1, 32'h0);
    lit_both("rst", 2, 32'h0);
    lit_both("rst", 3, 32'h0);
    lit_both("rst", 4, 32'h0);
    lit_both("rst", 5, 32'h1);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    repeat (4) tick();

    // Scan latency: (5,7) holds 1, (6,7) holds 0; third cycle reads a 1 with video off.
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      drive_idle();
      if (j == 1) begin
        pixel_x = 10'd5; pixel_y = 10'd7; video_on_in = 1; h_sync_in = 1;
      end else if (j == 2) begin
        pixel_x = 10'd6; pixel_y = 10'd7; video_on_in = 1; v_sync_in = 1;
      end else if (j == 3) begin
        pixel_x = 10'd5; pixel_y = 10'd7;
      end else begin
        pixel_y = 10'd20;
      end
      tick();
      chk($sformatf("lit_scan_lat1_c%0d", j), 32'({h_o[0], v_o[0], rgb_o[0]}), 32'(lit_a[j-1]));
      chk($sformatf("lit_scan_lat3_c%0d", j), 32'({h_o[1], v_o[1], rgb_o[1]}), 32'(lit_b[j-1]));
    end

    // Streaming draws: three in range back to back, then one off-screen.
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      drive_idle();
      draw_valid = (j <= 4);
      case (j)
        1: begin draw_x = 10'd0;   draw_y = 9'd0; end
        2: begin draw_x = 10'd1;   draw_y = 9'd1; end
        3: begin draw_x = 10'd2;   draw_y = 9'd2; end
        4: begin draw_x = 10'd700; draw_y = 9'd3; end
        default: ;
      endcase
      #1;
      if (j == 1) lit_both("draw_rdy", 5, 32'h1);
      tick();
      lit_both($sformatf("draw%0d", j), 0, (j <= 3) ? 32'h1 : 32'h0);
      if (j <= 3) begin
        lit_both($sformatf("draw%0d", j), 1, 32'h1);
        lit_both($sformatf("draw%0d", j), 2, (j == 1) ? 32'h0 : (j == 2) ? 32'h201 : 32'h402);
      end
    end

    // Clear request colliding with a held draw: clear wins, draw lands after done.
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      drive_idle();
      clear_req = (j == 1);
      draw_valid = 1'b1; draw_x = 10'd1; draw_y = 9'd2;
      #1;
      if (j == 1) lit_both("clr_rdy0", 5, 32'h0);
      tick();
      if (j <= 12) begin
        lit_both($sformatf("clr%0d", j), 0, 32'h1);
        lit_both($sformatf("clr%0d", j), 1, 32'h0);
        lit_both($sformatf("clr%0d", j), 2, 32'(clr_addr[j-1]));
        lit_both($sformatf("clr%0d", j), 3, 32'h1);
        lit_both($sformatf("clr%0d", j), 5, 32'h0);
      end else if (j == 13) begin
        lit_both("clr_done", 4, 32'h1);
        lit_both("clr_done", 0, 32'h0);
        lit_both("clr_done", 3, 32'h0);
      end else if (j == 14) begin
        lit_both("clr_idle", 4, 32'h0);
        lit_both("clr_idle", 5, 32'h1);
      end else begin
        lit_both("clr_draw", 0, 32'h1);
        lit_both("clr_draw", 1, 32'h1);
        lit_both("clr_draw", 2, 32'h202);
      end
    end
    @(negedge clk);
    drive_idle();
    repeat (2) tick();

    // Reset during the fifth clear write aborts with no done pulse.
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      drive_idle();
      clear_req = (j == 1);
      tick();
    end
    lit_both("abort_pre", 3, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    lit_both("abort", 3, 32'h0);
    lit_both("abort", 0, 32'h0);
    lit_both("abort", 4, 32'h0);
    for (int j = 0; j < 2; j++) begin
      tick();
      lit_both("abort_hold", 4, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      tick();
      lit_both("abort_after", 4, 32'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      pixel_x = 10'($urandom_range(0, 15));
      pixel_y = 10'($urandom_range(0, 15));
      h_sync_in = 1'($urandom); v_sync_in = 1'($urandom); video_on_in = 1'($urandom);
      draw_valid = 1'($urandom);
      draw_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                           : 10'($urandom_range(0, 5));
      draw_y = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                           : 9'($urandom_range(0, 3));
      clear_req = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
